// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and constants for the round sequencer, datapath and K ROM.
package sha256_pkg;

  localparam int unsigned ROUNDS    = 64;
  localparam int unsigned MSG_WORDS = 16;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ROUND,
    FINAL,
    DONE
  } state_e;

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// Job handshake and datapath strobes between the feeder, the round sequencer and the datapath.
interface sha256_round_ctrl_if #(
  parameter int unsigned CNT_W = 6
);

  logic             start;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             init_load;
  logic             round_issue;
  logic             state_update;
  logic             w_sel_msg;
  logic [CNT_W-1:0] round_idx;
  logic             final_add;
  logic             done;

  modport master (
    output start, abort,
    input  ready, busy, init_load, round_issue, state_update,
           w_sel_msg, round_idx, final_add, done
  );

  modport slave (
    input  start, abort,
    output ready, busy, init_load, round_issue, state_update,
           w_sel_msg, round_idx, final_add, done
  );

endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: INIT, 64 rounds with T1 latency wait, final H add, done pulse.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned T1_LAT = 1,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  sha256_round_ctrl_if.slave  bus
);

  localparam int unsigned      PH_W     = (T1_LAT > 0) ? $clog2(T1_LAT + 1) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(T1_LAT);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] IDX_MSG  = CNT_W'(MSG_WORDS);
  localparam logic             UPD_ON_ISSUE = (T1_LAT == 0);

  state_e           state;
  logic [PH_W-1:0]  phase;
  logic [PH_W-1:0]  phase_nxt;
  logic [CNT_W-1:0] idx_nxt;

  assign phase_nxt = phase + PH_W'(1);
  assign idx_nxt   = bus.round_idx + CNT_W'(1);

  // Every output is registered and set one edge ahead of the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      phase            <= '0;
      bus.ready        <= 1'b1;
      bus.busy         <= 1'b0;
      bus.init_load    <= 1'b0;
      bus.round_issue  <= 1'b0;
      bus.state_update <= 1'b0;
      bus.w_sel_msg    <= 1'b0;
      bus.round_idx    <= '0;
      bus.final_add    <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      bus.init_load    <= 1'b0;
      bus.round_issue  <= 1'b0;
      bus.state_update <= 1'b0;
      bus.final_add    <= 1'b0;
      bus.done         <= 1'b0;

      if (bus.abort) begin
        state         <= IDLE;
        phase         <= '0;
        bus.ready     <= 1'b1;
        bus.busy      <= 1'b0;
        bus.w_sel_msg <= 1'b0;
        bus.round_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state         <= INIT;
              bus.ready     <= 1'b0;
              bus.busy      <= 1'b1;
              bus.init_load <= 1'b1;
            end
          end
          INIT: begin
            state            <= ROUND;
            phase            <= '0;
            bus.round_idx    <= '0;
            bus.round_issue  <= 1'b1;
            bus.state_update <= UPD_ON_ISSUE;
            bus.w_sel_msg    <= (MSG_WORDS > 0);
          end
          ROUND: begin
            if (phase == PH_LAST) begin
              phase <= '0;
              // Equality compare keeps round_idx from ever passing the last round.
              if (bus.round_idx == IDX_LAST) begin
                state         <= FINAL;
                bus.round_idx <= '0;
                bus.w_sel_msg <= 1'b0;
                bus.final_add <= 1'b1;
              end else begin
                bus.round_idx    <= idx_nxt;
                bus.round_issue  <= 1'b1;
                bus.state_update <= UPD_ON_ISSUE;
                bus.w_sel_msg    <= (idx_nxt < IDX_MSG);
              end
            end else begin
              phase            <= phase_nxt;
              bus.state_update <= (phase_nxt == PH_LAST);
            end
          end
          FINAL: begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
          DONE: begin
            state     <= IDLE;
            bus.ready <= 1'b1;
          end
          default: begin
            state         <= IDLE;
            phase         <= '0;
            bus.ready     <= 1'b1;
            bus.busy      <= 1'b0;
            bus.w_sel_msg <= 1'b0;
            bus.round_idx <= '0;
          end
        endcase
      end
    end
  end

endmodule
